// File: rtl/pipeline_mem.sv
// MIPS MEM stage: EX/MEM pipeline register, word-addressed data RAM and a
// small memory-mapped peripheral block (timer, LEDs, switches, systick).
module pipeline_mem #(
   parameter int unsigned RAM_ADDR_W  = 8,
   parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] EX_ALUOut,
   input  logic [31:0] EX_rt_postForward,
   input  logic        EX_MemRead,
   input  logic        EX_MemWrite,
   input  logic        EX_RegWrite,
   input  logic [1:0]  EX_MemToReg,
   input  logic [4:0]  EX_WriteReg,
   input  logic [31:0] EX_PC_plus4,
   input  logic [7:0]  switch,
   output logic [31:0] EXMEMdata,
   output logic        MEM_RegWrite,
   output logic [4:0]  MEM_WriteReg,
   output logic [1:0]  MEM_MemToReg,
   output logic [31:0] MEM_PC_plus4,
   output logic [31:0] MEM_ReadData,
   output logic [7:0]  led,
   output logic        irq
);

   localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_W;

   localparam logic [31:0] OFF_TH      = 32'h00;
   localparam logic [31:0] OFF_TL      = 32'h04;
   localparam logic [31:0] OFF_TCON    = 32'h08;
   localparam logic [31:0] OFF_LED     = 32'h0C;
   localparam logic [31:0] OFF_SWITCH  = 32'h10;
   localparam logic [31:0] OFF_SYSTICK = 32'h14;

   logic [31:0] exmem_rt;
   logic        mem_read;
   logic        mem_write;

   logic [31:0] ram [RAM_DEPTH];
   logic [31:0] th;
   logic [31:0] tl;
   logic [2:0]  tcon;
   logic [31:0] systick;

   logic                  is_periph;
   logic [31:0]           offset;
   logic [RAM_ADDR_W-1:0] ram_idx;
   logic                  wr_ram;
   logic                  wr_th;
   logic                  wr_tl;
   logic                  wr_tcon;
   logic                  wr_led;
   logic                  timer_step;
   logic [31:0]           rd_data;

   // EX/MEM pipeline register, no stall
   always_ff @(posedge clk) begin
      if (reset) begin
         EXMEMdata    <= '0;
         exmem_rt     <= '0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         MEM_RegWrite <= 1'b0;
         MEM_WriteReg <= '0;
         MEM_MemToReg <= '0;
         MEM_PC_plus4 <= '0;
      end else begin
         EXMEMdata    <= EX_ALUOut;
         exmem_rt     <= EX_rt_postForward;
         mem_read     <= EX_MemRead;
         mem_write    <= EX_MemWrite;
         MEM_RegWrite <= EX_RegWrite;
         MEM_WriteReg <= EX_WriteReg;
         MEM_MemToReg <= EX_MemToReg;
         MEM_PC_plus4 <= EX_PC_plus4;
      end
   end

   assign is_periph = (EXMEMdata >= PERIPH_BASE);
   assign offset    = EXMEMdata - PERIPH_BASE;
   assign ram_idx   = EXMEMdata[RAM_ADDR_W+1:2];

   assign wr_ram  = mem_write & ~is_periph;
   assign wr_th   = mem_write & is_periph & (offset == OFF_TH);
   assign wr_tl   = mem_write & is_periph & (offset == OFF_TL);
   assign wr_tcon = mem_write & is_periph & (offset == OFF_TCON);
   assign wr_led  = mem_write & is_periph & (offset == OFF_LED);

   // A CPU write to TL or TCON suppresses the timer for that edge
   assign timer_step = tcon[0] & ~(wr_tl | wr_tcon);

   // Asynchronous read mux; sees pre-write state when read and write coincide
   always_comb begin
      rd_data = '0;
      if (!is_periph) begin
         rd_data = ram[ram_idx];
      end else begin
         case (offset)
            OFF_TH:      rd_data = th;
            OFF_TL:      rd_data = tl;
            OFF_TCON:    rd_data = {29'b0, tcon};
            OFF_LED:     rd_data = {24'b0, led};
            OFF_SWITCH:  rd_data = {24'b0, switch};
            OFF_SYSTICK: rd_data = systick;
            default:     rd_data = '0;
         endcase
      end
      MEM_ReadData = mem_read ? rd_data : '0;
   end

   // Peripheral registers and timer
   always_ff @(posedge clk) begin
      if (reset) begin
         th      <= '0;
         tl      <= '0;
         tcon    <= '0;
         led     <= '0;
         systick <= '0;
      end else begin
         systick <= systick + 32'd1;
         if (timer_step) begin
            if (tl == 32'hFFFF_FFFF) begin
               tl <= th;
               if (tcon[1]) tcon[2] <= 1'b1;
            end else begin
               tl <= tl + 32'd1;
            end
         end
         if (wr_th)   th   <= exmem_rt;
         if (wr_tl)   tl   <= exmem_rt;
         if (wr_tcon) tcon <= exmem_rt[2:0];
         if (wr_led)  led  <= exmem_rt[7:0];
      end
   end

   // Data RAM keeps its contents across reset
   always_ff @(posedge clk) begin
      if (!reset && wr_ram) ram[ram_idx] <= exmem_rt;
   end

   assign irq = tcon[1] & tcon[2];

endmodule

// File: tb/tb_pipeline_mem.sv
// Randomized bench for pipeline_mem against a transaction-level model of the
// RAM, peripherals and timer, plus directed scenarios with fixed expectations.
module tb_pipeline_mem;

   localparam logic [31:0] BASE = 32'h4000_0000;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] rt;
      logic        rd;
      logic        wr;
      logic        rw;
      logic [1:0]  m2r;
      logic [4:0]  wreg;
      logic [31:0] pc4;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] EX_ALUOut = '0;
   logic [31:0] EX_rt_postForward = '0;
   logic        EX_MemRead = 1'b0;
   logic        EX_MemWrite = 1'b0;
   logic        EX_RegWrite = 1'b0;
   logic [1:0]  EX_MemToReg = '0;
   logic [4:0]  EX_WriteReg = '0;
   logic [31:0] EX_PC_plus4 = '0;
   logic [7:0]  switch = '0;
   logic [31:0] EXMEMdata;
   logic        MEM_RegWrite;
   logic [4:0]  MEM_WriteReg;
   logic [1:0]  MEM_MemToReg;
   logic [31:0] MEM_PC_plus4;
   logic [31:0] MEM_ReadData;
   logic [7:0]  led;
   logic        irq;

   pipeline_mem dut (
      .clk(clk), .reset(reset),
      .EX_ALUOut(EX_ALUOut), .EX_rt_postForward(EX_rt_postForward),
      .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
      .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
      .EX_WriteReg(EX_WriteReg), .EX_PC_plus4(EX_PC_plus4),
      .switch(switch),
      .EXMEMdata(EXMEMdata), .MEM_RegWrite(MEM_RegWrite),
      .MEM_WriteReg(MEM_WriteReg), .MEM_MemToReg(MEM_MemToReg),
      .MEM_PC_plus4(MEM_PC_plus4), .MEM_ReadData(MEM_ReadData),
      .led(led), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   txn_t        m_cur = '0;
   logic [31:0] m_ram [256];
   logic [31:0] m_th = '0, m_tl = '0, m_systick = '0;
   logic [2:0]  m_tcon = '0;
   logic [7:0]  m_led = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] off;
      if (a < BASE) return m_ram[a[9:2]];
      off = a - BASE;
      if (off == 32'h00) return m_th;
      if (off == 32'h04) return m_tl;
      if (off == 32'h08) return {29'b0, m_tcon};
      if (off == 32'h0C) return {24'b0, m_led};
      if (off == 32'h10) return {24'b0, switch};
      if (off == 32'h14) return m_systick;
      return 32'h0;
   endfunction

   // One clock edge of the architectural model
   task automatic model_edge(input logic rst, input txn_t nx);
      logic [31:0] off;
      logic        to_periph;
      logic        blocked;
      if (rst) begin
         m_cur = '0; m_th = '0; m_tl = '0; m_tcon = '0; m_led = '0; m_systick = '0;
         return;
      end
      to_periph = (m_cur.alu >= BASE);
      off       = m_cur.alu - BASE;
      blocked   = m_cur.wr && to_periph && (off == 32'h04 || off == 32'h08);
      if (m_tcon[0] && !blocked) begin
         if (m_tl == 32'hFFFF_FFFF) begin
            m_tl = m_th;
            if (m_tcon[1]) m_tcon[2] = 1'b1;
         end else begin
            m_tl = m_tl + 1;
         end
      end
      if (m_cur.wr) begin
         if (!to_periph) m_ram[m_cur.alu[9:2]] = m_cur.rt;
         else if (off == 32'h00) m_th = m_cur.rt;
         else if (off == 32'h04) m_tl = m_cur.rt;
         else if (off == 32'h08) m_tcon = m_cur.rt[2:0];
         else if (off == 32'h0C) m_led = m_cur.rt[7:0];
      end
      m_systick = m_systick + 1;
      m_cur = nx;
   endtask

   task automatic compare_all();
      check_eq("exmemdata", EXMEMdata, m_cur.alu);
      check_eq("regwrite", 32'(MEM_RegWrite), 32'(m_cur.rw));
      check_eq("writereg", 32'(MEM_WriteReg), 32'(m_cur.wreg));
      check_eq("memtoreg", 32'(MEM_MemToReg), 32'(m_cur.m2r));
      check_eq("pc_plus4", MEM_PC_plus4, m_cur.pc4);
      check_eq("readdata", MEM_ReadData, m_cur.rd ? m_read(m_cur.alu) : 32'h0);
      check_eq("led", 32'(led), 32'(m_led));
      check_eq("irq", 32'(irq), 32'(m_tcon[1] & m_tcon[2]));
   endtask

   task automatic step(input logic rst, input txn_t t);
      reset             = rst;
      EX_ALUOut         = t.alu;
      EX_rt_postForward = t.rt;
      EX_MemRead        = t.rd;
      EX_MemWrite       = t.wr;
      EX_RegWrite       = t.rw;
      EX_MemToReg       = t.m2r;
      EX_WriteReg       = t.wreg;
      EX_PC_plus4       = t.pc4;
      @(posedge clk);
      model_edge(rst, t);
      #1;
      compare_all();
   endtask

   function automatic txn_t mk(input logic [31:0] a, input logic [31:0] d,
                               input logic rd, input logic wr);
      txn_t t = '0;
      t.alu = a; t.rt = d; t.rd = rd; t.wr = wr;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      int   k = int'($urandom_range(0, 9));
      if (k < 5)      t.alu = $urandom & 32'h3FFF_FFFF;
      else if (k < 9) t.alu = BASE + 32'($urandom_range(0, 8)) * 4;
      else            t.alu = BASE + $urandom;
      t.rt   = $urandom;
      if (t.alu == BASE + 32'h4 && $urandom_range(0, 1) == 1)
         t.rt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if (t.alu == BASE + 32'h8 && $urandom_range(0, 1) == 1)
         t.rt = 32'($urandom_range(0, 3));
      t.rd   = 1'($urandom_range(0, 1));
      t.wr   = ($urandom_range(0, 2) == 0);
      t.rw   = 1'($urandom_range(0, 1));
      t.m2r  = 2'($urandom_range(0, 2));
      t.wreg = 5'($urandom_range(0, 31));
      t.pc4  = $urandom;
      return t;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      txn_t t;
      for (int i = 0; i < 256; i++) m_ram[i] = '0;

      step(1'b1, mk(32'h0, 32'h0, 1'b0, 1'b0));
      step(1'b1, mk(32'h0, 32'h0, 1'b0, 1'b0));
      check_eq("reset_exmem", EXMEMdata, 32'h0);
      check_eq("reset_irq", 32'(irq), 32'h0);

      // Fill RAM so every word has a known value
      for (int i = 0; i < 256; i++) step(1'b0, mk(32'(i) * 4, $urandom, 1'b0, 1'b1));

      // Store then load with ignored byte offset
      step(1'b0, mk(32'h10, 32'h1234_5678, 1'b0, 1'b1));
      step(1'b0, mk(32'h13, 32'h0, 1'b1, 1'b0));
      check_eq("lw_after_sw", MEM_ReadData, 32'h1234_5678);
      step(1'b0, mk(32'h13, 32'h0, 1'b0, 1'b0));
      check_eq("no_memread", MEM_ReadData, 32'h0);

      // Pipeline latency
      t = mk(32'hA, 32'h0, 1'b0, 1'b0); t.rw = 1'b1; t.wreg = 5'd7;
      step(1'b0, t);
      check_eq("lat_alu", EXMEMdata, 32'hA);
      check_eq("lat_wreg", 32'(MEM_WriteReg), 32'd7);

      // Timer reload and interrupt
      step(1'b0, mk(BASE + 32'h0, 32'hFFFF_FFFD, 1'b0, 1'b1));
      step(1'b0, mk(BASE + 32'h4, 32'hFFFF_FFFD, 1'b0, 1'b1));
      step(1'b0, mk(BASE + 32'h8, 32'h3, 1'b0, 1'b1));
      step(1'b0, mk(BASE + 32'h4, 32'h0, 1'b1, 1'b0));
      check_eq("tl_start", MEM_ReadData, 32'hFFFF_FFFD);
      step(1'b0, mk(BASE + 32'h4, 32'h0, 1'b1, 1'b0));
      check_eq("tl_step1", MEM_ReadData, 32'hFFFF_FFFE);
      step(1'b0, mk(BASE + 32'h4, 32'h0, 1'b1, 1'b0));
      check_eq("tl_step2", MEM_ReadData, 32'hFFFF_FFFF);
      step(1'b0, mk(BASE + 32'h4, 32'h0, 1'b1, 1'b0));
      check_eq("tl_reload", MEM_ReadData, 32'hFFFF_FFFD);
      check_eq("irq_set", 32'(irq), 32'h1);
      step(1'b0, mk(BASE + 32'h8, 32'h3, 1'b0, 1'b1));
      step(1'b0, mk(BASE + 32'h8, 32'h0, 1'b1, 1'b0));
      check_eq("irq_clear", 32'(irq), 32'h0);
      check_eq("tcon_after_clear", MEM_ReadData, 32'h3);

      // LEDs, switches, unmapped offset
      step(1'b0, mk(BASE + 32'hC, 32'h0000_01A5, 1'b0, 1'b1));
      step(1'b0, mk(32'h0, 32'h0, 1'b0, 1'b0));
      check_eq("led_write", 32'(led), 32'hA5);
      switch = 8'h3C;
      step(1'b0, mk(BASE + 32'h10, 32'h0, 1'b1, 1'b0));
      check_eq("switch_read", MEM_ReadData, 32'h3C);
      step(1'b0, mk(BASE + 32'h20, 32'h0, 1'b1, 1'b0));
      check_eq("unmapped_read", MEM_ReadData, 32'h0);

      // TL write while counting
      step(1'b0, mk(BASE + 32'h4, 32'h100, 1'b0, 1'b1));
      step(1'b0, mk(BASE + 32'h4, 32'h0, 1'b1, 1'b0));
      check_eq("tl_written", MEM_ReadData, 32'h100);
      step(1'b0, mk(BASE + 32'h4, 32'h0, 1'b1, 1'b0));
      check_eq("tl_written_p1", MEM_ReadData, 32'h101);

      // Reset while irq is pending
      step(1'b0, mk(BASE + 32'h4, 32'hFFFF_FFFF, 1'b0, 1'b1));
      step(1'b0, mk(32'h0, 32'h0, 1'b0, 1'b0));
      step(1'b0, mk(32'h0, 32'h0, 1'b0, 1'b0));
      check_eq("irq_before_rst", 32'(irq), 32'h1);
      step(1'b1, mk(32'h55, 32'h0, 1'b1, 1'b1));
      check_eq("rst_irq", 32'(irq), 32'h0);
      check_eq("rst_led", 32'(led), 32'h0);
      check_eq("rst_exmem", EXMEMdata, 32'h0);
      step(1'b0, mk(BASE + 32'h4, 32'h0, 1'b1, 1'b0));
      check_eq("rst_tl", MEM_ReadData, 32'h0);
      step(1'b0, mk(32'h10, 32'h0, 1'b1, 1'b0));
      check_eq("ram_kept", MEM_ReadData, 32'h1234_5678);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
         step(($urandom_range(0, 299) == 0), rand_txn());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_mem.md
Name: pipeline_MEM

Overview:
Memory stage of the 5-stage MIPS pipeline, directly downstream of the EX stage. Latches the EX results into the EX/MEM pipeline register. Performs lw/sw accesses to a word-addressed data RAM or to a memory-mapped peripheral block (timer, LEDs, switches, systick). Presents the ALU result back to EX as the EX/MEM forwarding source, and presents the loaded data and control to the MEM/WB register.

Parameters:
RAM_ADDR_W, 8, data RAM word-address width (2^RAM_ADDR_W words).
PERIPH_BASE, 32'h40000000, base byte address of the peripheral window.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
EX_ALUOut  input  32  ALU result / memory byte address from EX
EX_rt_postForward  input  32  forwarded rt value, store data
EX_MemRead  input  1  lw in EX
EX_MemWrite  input  1  sw in EX
EX_RegWrite  input  1  instruction writes register file
EX_MemToReg  input  2  writeback select (0 ALU, 1 mem, 2 PC+4)
EX_WriteReg  input  5  destination register number
EX_PC_plus4  input  32  PC+4 of the instruction
switch  input  8  board switches
EXMEMdata  output  32  registered ALU result (forwarding source to EX)
MEM_RegWrite  output  1  registered EX_RegWrite
MEM_WriteReg  output  5  registered EX_WriteReg
MEM_MemToReg  output  2  registered EX_MemToReg
MEM_PC_plus4  output  32  registered EX_PC_plus4
MEM_ReadData  output  32  load data, combinational within the MEM cycle
led  output  8  LED register
irq  output  1  timer interrupt request

Behaviour:
- Reset (synchronous): on a rising edge with reset=1, all EX/MEM register fields clear to 0, including internal MemRead, MemWrite and store data.
  - TH, TL, TCON, led and systick clear to 0, so irq=0.
  - RAM contents are not cleared.
  - Reset has priority over every write and every count in the same edge.
- EX/MEM register: loads every EX_* input at each rising edge with no stall or enable, giving 1-cycle latency. EXMEMdata equals the registered EX_ALUOut.
- Address decode uses the registered address A:
  - A < PERIPH_BASE selects RAM. Word index = A[RAM_ADDR_W+1:2]. A[1:0] is ignored, and higher bits wrap modulo the RAM size.
  - A >= PERIPH_BASE selects a peripheral by offset: 0x00 TH (R/W), 0x04 TL (R/W), 0x08 TCON (R/W, bits[2:0]), 0x0C led (R/W, bits[7:0]), 0x10 switch (read-only), 0x14 systick (read-only). All other offsets are unmapped.
- Read path:
  - MEM_ReadData = selected data when the registered MemRead=1, else 0.
  - Narrow registers are zero-extended.
  - Unmapped peripheral offsets read 0.
  - Reads are asynchronous within the MEM cycle.
- Write path:
  - When the registered MemWrite=1, the registered store data is written at the rising edge that ends the MEM cycle.
  - led takes data[7:0]; TCON takes data[2:0].
  - Writes to read-only or unmapped offsets are ignored.
  - A lw to the same address in the next cycle returns the new value.
- Timer: TCON[0] = enable, TCON[1] = interrupt enable, TCON[2] = status.
  - When enabled, TL increments by 1 each cycle.
  - When TL = 0xFFFFFFFF and enabled: TL <= TH instead of wrapping, and TCON[2] <= 1 if TCON[1]=1.
  - irq = TCON[1] & TCON[2], registered-state driven.
  - Status clears only by a CPU write to TCON.
- Simultaneous events: a CPU write to TL or TCON in the same edge as a timer increment or overflow wins outright; the written value is stored and no increment or status set occurs that edge.
- systick: increments every cycle from reset and wraps at 2^32.
- MemRead and MemWrite both 1: a write occurs, and the read returns the pre-write value.

Test Plan:
1. Release reset, present sw to address 0x10 with store data 0x12345678, followed by lw from 0x13 -> MEM_ReadData=0x12345678 during the lw MEM cycle; read with MemRead=0 gives 0.
2. EX_ALUOut=0xA, EX_RegWrite=1, EX_WriteReg=7 at edge n -> EXMEMdata=0xA, MEM_RegWrite=1, MEM_WriteReg=7 after edge n; the next input appears one cycle later.
3. Write TH=0xFFFFFFFD, TL=0xFFFFFFFD, then TCON=3 -> TL steps to 0xFFFFFFFE, then 0xFFFFFFFF, then reloads 0xFFFFFFFD with TCON=7 and irq=1; a later write TCON=3 gives irq=0.
4. sw 0x000001A5 to 0x4000000C -> led=0xA5. switch=0x3C and lw 0x40000010 -> 0x0000003C. lw 0x40000020 -> 0.
5. With the timer enabled, write TL=0x100 -> the next read of TL (after the write edge) sees 0x100 plus cycles elapsed since that edge, with no skipped increment collision.
6. Assert reset for one edge while the timer runs and irq=1 -> irq=0, led=0, TL=0, EXMEMdata=0 after the edge; RAM data written earlier still reads back.
